// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction store behind a valid/ready fetch
// port. Responses come back in order after a fixed pipeline latency, and a
// small output buffer absorbs consumer backpressure. A separate load port
// preloads program images.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW   = $clog2(LATENCY + 2);
   localparam int PW   = $clog2(LATENCY + 1);
   localparam int FD   = LATENCY + 1;
   localparam int LAST = LATENCY - 1;
   localparam logic [CW-1:0] OUT_LIMIT = CW'(LATENCY + 1);
   localparam logic [PW-1:0] PTR_LAST  = PW'(LATENCY);
   localparam logic [31:0]   DEPTH_32  = 32'(DEPTH_WORDS);

   // Instruction store (not cleared by reset)
   logic [31:0] mem [0:DEPTH_WORDS-1];

   // Address decode: subtraction wraps, so addresses below the base land far
   // out of range and are caught by the same depth compare.
   logic [31:0]   req_off, load_off;
   logic [AW-1:0] req_idx, load_idx;
   logic          req_bad, load_ok;

   assign req_off  = req_addr - BASE_ADDR;
   assign req_bad  = (req_off[1:0] != 2'b00) || ({2'b00, req_off[31:2]} >= DEPTH_32);
   assign req_idx  = req_off[AW+1:2];
   assign load_off = load_addr - BASE_ADDR;
   assign load_ok  = (load_off[1:0] == 2'b00) && ({2'b00, load_off[31:2]} < DEPTH_32);
   assign load_idx = load_off[AW+1:2];

   // Handshake bookkeeping
   logic [CW-1:0] outstanding_reg;
   logic          accept, deliver;

   assign req_ready = reset_n && (outstanding_reg < OUT_LIMIT);
   assign accept    = req_valid && req_ready;

   // Pipeline state; stage 0 data is the registered store read
   logic [31:0] data_pipe_reg  [0:LAST];
   logic        valid_pipe_reg [0:LAST];
   logic        err_pipe_reg   [0:LAST];

   // Store write and read-first registered read into pipeline stage 0
   always_ff @(posedge clk) begin
      if (load_en && load_ok) begin
         mem[load_idx] <= load_data;
      end
      if (accept) begin
         data_pipe_reg[0] <= mem[req_idx];
      end
   end

   // Stage 0 control: capture accept and its decode error
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_pipe_reg[0] <= 1'b0;
         err_pipe_reg[0]   <= 1'b0;
      end else begin
         valid_pipe_reg[0] <= accept;
         err_pipe_reg[0]   <= req_bad;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < LATENCY; gi++) begin : g_stage
         // Shift one pipeline stage forward every cycle
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               valid_pipe_reg[gi] <= 1'b0;
               err_pipe_reg[gi]   <= 1'b0;
            end else begin
               valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
               err_pipe_reg[gi]   <= err_pipe_reg[gi-1];
            end
            data_pipe_reg[gi] <= data_pipe_reg[gi-1];
         end
      end
   endgenerate

   // Output buffer. When it is empty the last pipeline stage is presented
   // directly; if not taken it drops into the buffer and stays at the head,
   // so presented values never change while stalled.
   logic [31:0]   fifo_data_reg [0:FD-1];
   logic          fifo_err_reg  [0:FD-1];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] fifo_cnt_reg;
   logic          fifo_empty, head_valid, head_err, push, pop;
   logic [31:0]   head_data;

   assign fifo_empty = (fifo_cnt_reg == '0);
   assign head_valid = !fifo_empty || valid_pipe_reg[LAST];
   assign head_err   = fifo_empty ? err_pipe_reg[LAST]  : fifo_err_reg[rd_ptr_reg];
   assign head_data  = fifo_empty ? data_pipe_reg[LAST] : fifo_data_reg[rd_ptr_reg];
   assign deliver    = head_valid && rsp_ready;
   assign push       = valid_pipe_reg[LAST] && !(fifo_empty && deliver);
   assign pop        = deliver && !fifo_empty;

   assign rsp_valid = head_valid;
   assign rsp_err   = head_valid && head_err;
   assign rsp_data  = (head_valid && !head_err) ? head_data : 32'h0;

   // Buffer storage write (no reset needed, occupancy guards it)
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_reg[wr_ptr_reg] <= data_pipe_reg[LAST];
         fifo_err_reg[wr_ptr_reg]  <= err_pipe_reg[LAST];
      end
   end

   // Buffer pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
         end
         if (push && !pop) begin
            fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
         end else if (!push && pop) begin
            fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
         end
      end
   end

   // Requests accepted but not yet delivered
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         outstanding_reg <= '0;
      end else if (accept && !deliver) begin
         outstanding_reg <= outstanding_reg + CW'(1);
      end else if (!accept && deliver) begin
         outstanding_reg <= outstanding_reg - CW'(1);
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: scenario tasks driven from one initial block,
// checked against a queue-based reference model of the fetch/response rules.
module tb_imem_responder;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_en;
   logic [31:0] req_addr, rsp_data, load_addr, load_data;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   typedef struct { logic [31:0] data; logic err; int due; } rsp_t;
   typedef struct { logic rr; logic rv; logic re; logic [31:0] rd; } sig_t;

   rsp_t        exp_q[$];
   logic [31:0] model_mem [0:DEPTH-1];
   int          cyc = 0;
   int          tests_run = 0;
   int          failed = 0;

   function automatic bit addr_bad(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      return (a % 4 != 0) || (off < 0) || (off / 4 >= longint'(DEPTH));
   endfunction

   function automatic int addr_word(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   // One cycle: sample DUT, form model expectations, advance the model and clock.
   task automatic step(output sig_t o, output sig_t x);
      rsp_t e;
      #1;
      o.rr = req_ready; o.rv = rsp_valid; o.rd = rsp_data; o.re = rsp_err;
      x.rr = reset_n && (exp_q.size() < int'(LAT + 1));
      x.rv = 1'b0; x.rd = 32'h0; x.re = 1'b0;
      if (exp_q.size() > 0) begin
         if (cyc >= exp_q[0].due) begin
            x.rv = 1'b1; x.rd = exp_q[0].data; x.re = exp_q[0].err;
         end
      end
      if (!reset_n) begin
         exp_q.delete();
      end else begin
         if (x.rv && rsp_ready) void'(exp_q.pop_front());
         if (req_valid && x.rr) begin
            e.err  = addr_bad(req_addr);
            e.data = e.err ? 32'h0 : model_mem[addr_word(req_addr)];
            e.due  = cyc + int'(LAT);
            exp_q.push_back(e);
         end
      end
      if (load_en && !addr_bad(load_addr)) model_mem[addr_word(load_addr)] = load_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      sig_t o, x;
      load_en = 1'b1; load_addr = a; load_data = d;
      step(o, x);
      load_en = 1'b0;
   endtask

   task automatic test_reset();
      sig_t o, x;
      reset_n = 1'b0; req_valid = 1'b1; req_addr = BASE; rsp_ready = 1'b1; load_en = 1'b0;
      load_addr = 32'h0; load_data = 32'h0;
      for (int i = 0; i < 3; i++) begin
         step(o, x);
         tests_run++;
         if (o.rr !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b want 0", o.rr); end
         if (i > 0) begin
            tests_run++;
            if (o.rv !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", o.rv); end
         end
      end
      reset_n = 1'b1; req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(o, x);
         tests_run++;
         if (o.rr !== 1'b1 || o.rv !== 1'b0 || o.rd !== 32'h0 || o.re !== 1'b0) begin
            failed++;
            $display("FAIL reset_release: rr=%b rv=%b rd=%h re=%b want rr=1 rv=0 rd=0 re=0", o.rr, o.rv, o.rd, o.re);
         end
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_preload_fetch();
      sig_t o, x;
      int first = -1;
      load_word(32'h0040_0020, 32'h8C22_0004);
      req_valid = 1'b1; req_addr = 32'h0040_0020; rsp_ready = 1'b1;
      step(o, x);
      req_valid = 1'b0;
      tests_run++;
      if (o.rr !== 1'b1) begin failed++; $display("FAIL preload_accept: ready got %b want 1", o.rr); end
      for (int i = 1; i <= 4; i++) begin
         step(o, x);
         if (o.rv === 1'b1 && first < 0) begin
            first = i;
            tests_run++;
            if (o.rd !== 32'h8C22_0004 || o.re !== 1'b0) begin
               failed++; $display("FAIL preload_data: got %h/%b want 8c220004/0", o.rd, o.re);
            end
         end
      end
      tests_run++;
      if (first != int'(LAT)) begin failed++; $display("FAIL preload_latency: got %0d want %0d", first, LAT); end
      $display("[TB] test_preload_fetch: response after %0d cycles", first);
   endtask

   task automatic test_streaming();
      sig_t o, x;
      logic [31:0] vals [8];
      int got = 0;
      for (int k = 0; k < 8; k++) begin
         vals[k] = $urandom;
         load_word(BASE + 32'(4 * k), vals[k]);
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 8 + int'(LAT) + 2; i++) begin
         if (i < 8) begin req_valid = 1'b1; req_addr = BASE + 32'(4 * i); end
         else req_valid = 1'b0;
         step(o, x);
         tests_run++;
         if (o.rr !== 1'b1) begin failed++; $display("FAIL stream_ready c%0d: got %b want 1", i, o.rr); end
         tests_run++;
         if (o.rv !== (i >= int'(LAT) && i < int'(LAT) + 8)) begin
            failed++; $display("FAIL stream_valid c%0d: got %b", i, o.rv);
         end
         if (o.rv === 1'b1 && got < 8) begin
            tests_run++;
            if (o.rd !== vals[got] || o.re !== 1'b0) begin
               failed++; $display("FAIL stream_data #%0d: got %h want %h", got, o.rd, vals[got]);
            end
            got++;
         end
      end
      tests_run++;
      if (got != 8) begin failed++; $display("FAIL stream_count: got %0d want 8", got); end
      $display("[TB] test_streaming: %0d responses", got);
   endtask

   task automatic test_backpressure();
      sig_t o, x;
      int acc = 0, dlv = 0;
      for (int k = 0; k < 3; k++) load_word(BASE + 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));
      rsp_ready = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = BASE + 32'h100 + 32'(4 * acc);
         step(o, x);
         tests_run++;
         if (o.rr !== (i < int'(LAT) + 1)) begin failed++; $display("FAIL bp_ready c%0d: got %b", i, o.rr); end
         if (o.rr === 1'b1) acc++;
      end
      tests_run++;
      if (acc != int'(LAT) + 1) begin failed++; $display("FAIL bp_accepts: got %0d want %0d", acc, LAT + 1); end
      req_valid = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(o, x);
         tests_run++;
         if (o.rr !== (i >= 1)) begin failed++; $display("FAIL bp_ready_drain c%0d: got %b", i, o.rr); end
         if (o.rv === 1'b1) begin
            tests_run++;
            if (o.rd !== 32'hA000_0000 + 32'(dlv)) begin
               failed++; $display("FAIL bp_order #%0d: got %h want %h", dlv, o.rd, 32'hA000_0000 + 32'(dlv));
            end
            dlv++;
         end
      end
      tests_run++;
      if (dlv != 3) begin failed++; $display("FAIL bp_delivered: got %0d want 3", dlv); end
      $display("[TB] test_backpressure: %0d accepted, %0d delivered", acc, dlv);
   endtask

   task automatic test_errors();
      sig_t o, x;
      logic [31:0] addrs [5];
      logic        errs [5];
      int got = 0;
      addrs = '{BASE + 32'h4, 32'h0040_0022, BASE + 32'(4 * DEPTH), 32'h003F_FFFC, BASE + 32'h8};
      errs  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      rsp_ready = 1'b1;
      for (int i = 0; i < 5 + int'(LAT) + 2; i++) begin
         if (i < 5) begin req_valid = 1'b1; req_addr = addrs[i]; end
         else req_valid = 1'b0;
         step(o, x);
         if (o.rv === 1'b1 && got < 5) begin
            tests_run++;
            if (o.re !== errs[got] || o.rd !== x.rd || (errs[got] && o.rd !== 32'h0)) begin
               failed++;
               $display("FAIL err_rsp #%0d addr %h: got %h/%b want %h/%b", got, addrs[got], o.rd, o.re, x.rd, errs[got]);
            end
            got++;
         end
      end
      tests_run++;
      if (got != 5) begin failed++; $display("FAIL err_count: got %0d want 5", got); end
      $display("[TB] test_errors: %0d responses", got);
   endtask

   task automatic test_same_cycle();
      sig_t o, x;
      logic [31:0] got [2];
      int n = 0;
      load_word(32'h0040_0040, 32'h1111_1111);
      rsp_ready = 1'b1;
      load_en = 1'b1; load_addr = 32'h0040_0040; load_data = 32'h2222_2222;
      req_valid = 1'b1; req_addr = 32'h0040_0040;
      step(o, x);
      load_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_valid = (i == 0);
         step(o, x);
         if (o.rv === 1'b1 && n < 2) begin got[n] = o.rd; n++; end
      end
      tests_run++;
      if (n != 2) begin failed++; $display("FAIL rbw_count: got %0d want 2", n); end
      else begin
         tests_run++;
         if (got[0] !== 32'h1111_1111) begin failed++; $display("FAIL rbw_old: got %h want 11111111", got[0]); end
         tests_run++;
         if (got[1] !== 32'h2222_2222) begin failed++; $display("FAIL rbw_new: got %h want 22222222", got[1]); end
      end
      $display("[TB] test_same_cycle: %0d responses", n);
   endtask

   task automatic test_reset_midflight();
      sig_t o, x;
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE;
      step(o, x);
      step(o, x);
      req_valid = 1'b0; reset_n = 1'b0;
      step(o, x);
      reset_n = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(o, x);
         tests_run++;
         if (o.rv !== 1'b0) begin failed++; $display("FAIL midreset_stale c%0d: rsp_valid got %b want 0", i, o.rv); end
      end
      $display("[TB] test_reset_midflight done");
   endtask

   task automatic test_random();
      sig_t o, x;
      int r, nrsp = 0;
      for (int k = 0; k < 64; k++) load_word(BASE + 32'(4 * k), $urandom);
      for (int n = 0; n < 400 + int'(LAT) + 4; n++) begin
         if (n < 400) begin
            reset_n   = ($urandom_range(0, 49) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 7)       req_addr = BASE + 4 * $urandom_range(0, 63);
            else if (r == 7) req_addr = BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else if (r == 8) req_addr = BASE - 4 * $urandom_range(1, 4);
            else             req_addr = BASE + 32'(4 * DEPTH) + 4 * $urandom_range(0, 3);
            rsp_ready = ($urandom_range(0, 2) != 0);
            load_en   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0)
               load_addr = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : BASE + 32'(4 * DEPTH);
            else
               load_addr = BASE + 4 * $urandom_range(0, 63);
            load_data = $urandom;
         end else begin
            reset_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; load_en = 1'b0;
         end
         step(o, x);
         tests_run++;
         if (o.rr !== x.rr || o.rv !== x.rv) begin
            failed++; $display("FAIL rand_hs c%0d: rr/rv got %b%b want %b%b", n, o.rr, o.rv, x.rr, x.rv);
         end
         if (x.rv === 1'b1) begin
            nrsp++;
            tests_run++;
            if (o.rd !== x.rd || o.re !== x.re) begin
               failed++; $display("FAIL rand_rsp c%0d: got %h/%b want %h/%b", n, o.rd, o.re, x.rd, x.re);
            end
         end
      end
      $display("[TB] test_random: %0d response cycles checked", nrsp);
   endtask

   initial begin
      test_reset();
      test_preload_fetch();
      test_streaming();
      test_backpressure();
      test_errors();
      test_same_cycle();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
